// File: rtl/dmem_arbiter.sv
// Purpose : two-port (CPU / debug) arbiter and 3-state access sequencer for the data memory.
// Latency : request seen in IDLE at cycle N -> one ACC cycle -> ack in cycle N+2 (3 cycles per access).
// Backpressure: requesters hold req/we/addr/wdata until their one-cycle ack; cpu_stall mirrors a pending CPU access.
//
// Optional build macro: DMEM_ALIGN_CHK_EN -- when defined, a word access whose
// address is not 4-byte aligned is flagged as an error and never reaches the memory.
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata            CPU MEM-stage request (held until cpu_ack)
//   cpu_rdata/ack/err, cpu_stall     CPU response; cpu_stall = cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata            debug/loader request (held until dbg_ack)
//   dbg_rdata/ack/err                debug response
//   cs_ram, we, oe, d_addr, d_in     memory control/address/write-data pins (active in ACC only)
//   d_out                            memory read data, combinational from the memory
module dmem_arbiter #(
   parameter int WIDTH_D = 32,
   parameter int DEPTH_D = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [WIDTH_D-1:0] cpu_addr,
   input  logic [WIDTH_D-1:0] cpu_wdata,
   output logic [WIDTH_D-1:0] cpu_rdata,
   output logic               cpu_ack,
   output logic               cpu_err,
   output logic               cpu_stall,
   input  logic               dbg_req,
   input  logic               dbg_we,
   input  logic [WIDTH_D-1:0] dbg_addr,
   input  logic [WIDTH_D-1:0] dbg_wdata,
   output logic [WIDTH_D-1:0] dbg_rdata,
   output logic               dbg_ack,
   output logic               dbg_err,
   output logic               cs_ram,
   output logic               we,
   output logic               oe,
   output logic [WIDTH_D-1:0] d_addr,
   output logic [WIDTH_D-1:0] d_in,
   input  logic [WIDTH_D-1:0] d_out
);

   // Highest legal word base address.
   localparam logic [WIDTH_D-1:0] LP_MAX_ADDR = WIDTH_D'(DEPTH_D - 4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_rr_ptr;    // 0: CPU wins a tie, 1: debug wins a tie
   logic               r_owner;     // 0: CPU owns the access, 1: debug
   logic               r_we_l;
   logic               r_err_l;
   logic [WIDTH_D-1:0] r_addr_l;
   logic [WIDTH_D-1:0] r_wdata_l;
   logic [WIDTH_D-1:0] r_cpu_rdata;
   logic [WIDTH_D-1:0] r_dbg_rdata;

   logic               w_req_any;
   logic               w_gnt_dbg;
   logic               w_we_sel;
   logic [WIDTH_D-1:0] w_addr_sel;
   logic [WIDTH_D-1:0] w_wdata_sel;
   logic               w_err_sel;
   logic [WIDTH_D-1:0] w_rd_cap;

   // Arbitration: a lone request wins; on a tie the round-robin pointer decides.
   assign w_req_any   = cpu_req | dbg_req;
   assign w_gnt_dbg   = dbg_req & (~cpu_req | r_rr_ptr);
   assign w_we_sel    = w_gnt_dbg ? dbg_we    : cpu_we;
   assign w_addr_sel  = w_gnt_dbg ? dbg_addr  : cpu_addr;
   assign w_wdata_sel = w_gnt_dbg ? dbg_wdata : cpu_wdata;

`ifdef DMEM_ALIGN_CHK_EN
   assign w_err_sel = (w_addr_sel > LP_MAX_ADDR) | (w_addr_sel[1:0] != 2'b00);
`else
   assign w_err_sel = (w_addr_sel > LP_MAX_ADDR);
`endif

   // Only an error-free load returns memory data; writes and errors return zero.
   assign w_rd_cap = (~r_we_l & ~r_err_l) ? d_out : '0;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and memory / response outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      cs_ram      = 1'b0;
      we          = 1'b0;
      oe          = 1'b0;
      d_addr      = '0;
      d_in        = '0;
      cpu_ack     = 1'b0;
      cpu_err     = 1'b0;
      dbg_ack     = 1'b0;
      dbg_err     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_ACC;
            end
         end
         ST_ACC: begin
            cs_ram      = ~r_err_l;
            we          = r_we_l & ~r_err_l;
            oe          = ~r_we_l & ~r_err_l;
            d_addr      = r_addr_l;
            d_in        = r_wdata_l;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            cpu_ack     = ~r_owner;
            cpu_err     = ~r_owner & r_err_l;
            dbg_ack     = r_owner;
            dbg_err     = r_owner & r_err_l;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch, round-robin pointer and read-data capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= 1'b0;
         r_owner     <= 1'b0;
         r_we_l      <= 1'b0;
         r_err_l     <= 1'b0;
         r_addr_l    <= '0;
         r_wdata_l   <= '0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_req_any) begin
            r_owner   <= w_gnt_dbg;
            r_we_l    <= w_we_sel;
            r_addr_l  <= w_addr_sel;
            r_wdata_l <= w_wdata_sel;
            r_err_l   <= w_err_sel;
            // Point at the port that just lost (or did not ask) so it wins the next tie.
            r_rr_ptr  <= ~w_gnt_dbg;
         end
         if (r_state == ST_ACC) begin
            if (r_owner) begin
               r_dbg_rdata <= w_rd_cap;
            end else begin
               r_cpu_rdata <= w_rd_cap;
            end
         end
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign dbg_rdata = r_dbg_rdata;
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed self-checking bench for dmem_arbiter with a byte-addressed memory model.
// Latency : expects ack two cycles after the request is first seen in IDLE.
// Backpressure: requests are held until ack and dropped in the following cycle.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_err;
   logic        cpu_stall;
   logic        dbg_req = 1'b0;
   logic        dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic [31:0] dbg_rdata;
   logic        dbg_ack;
   logic        dbg_err;
   logic        cs_ram;
   logic        we;
   logic        oe;
   logic [31:0] d_addr;
   logic [31:0] d_in;
   logic [31:0] d_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.WIDTH_D(32), .DEPTH_D(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
      .cs_ram(cs_ram), .we(we), .oe(oe), .d_addr(d_addr), .d_in(d_in), .d_out(d_out)
   );

   // ---------------- byte-addressed memory model (256 bytes, little-endian) ----------------
   logic [7:0] mem [256];
   bit         mem_loaded = 1'b0;

   function automatic logic [7:0] idx(input logic [31:0] a, input int k);
      return 8'(a + 32'(k));
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem[idx(a, 3)], mem[idx(a, 2)], mem[idx(a, 1)], mem[idx(a, 0)]};
   endfunction

   assign d_out = {mem[idx(d_addr, 3)], mem[idx(d_addr, 2)], mem[idx(d_addr, 1)], mem[idx(d_addr, 0)]};

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
         mem_loaded <= 1'b1;
      end else if (cs_ram && we) begin
         for (int k = 0; k < 4; k++) mem[idx(d_addr, k)] <= d_in[8*k +: 8];
      end
   end

   // ---------------- single-port access driver (no checking) ----------------
   // Called #1 after a rising edge; returns the ack cycle relative to the request
   // cycle (-1 on timeout) and how often / when the memory pins were seen active.
   task automatic run_access(input bit port, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat,
                             output logic [31:0] rdata, output logic err,
                             output int cs_n, output int we_n, output int oe_n,
                             output int cs_at);
      lat = -1; rdata = '0; err = 1'b0; cs_n = 0; we_n = 0; oe_n = 0; cs_at = -1;
      if (port) begin
         dbg_req = 1'b1; dbg_we = wr; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = wr; cpu_addr = addr; cpu_wdata = wdata;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (cs_ram) begin cs_n++; cs_at = c; end
         if (we) we_n++;
         if (oe) oe_n++;
         if (port ? dbg_ack : cpu_ack) begin
            lat   = c;
            rdata = port ? dbg_rdata : cpu_rdata;
            err   = port ? dbg_err : cpu_err;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({cs_ram, we, oe, cpu_ack, cpu_err, dbg_ack, dbg_err, cpu_stall} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl: got %b required 00000000", {cs_ram, we, oe, cpu_ack, cpu_err, dbg_ack, dbg_err, cpu_stall});
      end
      checks++;
      if ({d_addr, d_in, cpu_rdata, dbg_rdata} !== 128'h0) begin
         errors++; $display("FAIL reset_data: d_addr=%h d_in=%h cpu_rdata=%h dbg_rdata=%h required all 0", d_addr, d_in, cpu_rdata, dbg_rdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (cs_ram || cpu_ack || dbg_ack) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL idle_quiet: active cycles=%0d required 0", bad);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cpu_store_load();
      int lat, cs_n, we_n, oe_n, cs_at;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d required 2", lat); end
      checks++;
      if (cs_n !== 1 || we_n !== 1 || oe_n !== 0 || cs_at !== 1) begin
         errors++; $display("FAIL store_pins: cs=%0d we=%0d oe=%0d cs_at=%0d required 1 1 0 1", cs_n, we_n, oe_n, cs_at);
      end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b required 0", er); end
      checks++;
      if (mem_word(32'h10) !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_mem: got %h required deadbeef", mem_word(32'h10));
      end
      run_access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d required 2", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++; $display("FAIL load_data: got %h err=%b required deadbeef err=0", rd, er);
      end
      checks++;
      if (oe_n !== 1 || we_n !== 0) begin
         errors++; $display("FAIL load_pins: oe=%0d we=%0d required 1 0", oe_n, we_n);
      end
   endtask

   task automatic test_contention();
      int ack_cyc[4];
      bit ack_dbg[4];
      int n;
      int both;
      logic [31:0] rd_seen[4];
      n = 0; both = 0;
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 30 && n < 4; c++) begin
         @(negedge clk);
         if (cpu_ack && dbg_ack) both++;
         if (cpu_ack) begin ack_cyc[n] = c; ack_dbg[n] = 1'b0; rd_seen[n] = cpu_rdata; n++; end
         else if (dbg_ack) begin ack_cyc[n] = c; ack_dbg[n] = 1'b1; rd_seen[n] = dbg_rdata; n++; end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      checks++;
      if (n !== 4 || both !== 0) begin
         errors++; $display("FAIL contention_count: acks=%0d simultaneous=%0d required 4 0", n, both);
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (ack_cyc[i] !== 2 + 3 * i || ack_dbg[i] !== 1'(i % 2)) begin
            errors++; $display("FAIL contention_order[%0d]: cycle=%0d dbg=%b required cycle=%0d dbg=%b", i, ack_cyc[i], ack_dbg[i], 2 + 3 * i, 1'(i % 2));
         end
         checks++;
         if (rd_seen[i] !== ((i % 2) ? 32'h23222120 : 32'hDEADBEEF)) begin
            errors++; $display("FAIL contention_rdata[%0d]: got %h required %h", i, rd_seen[i], (i % 2) ? 32'h23222120 : 32'hDEADBEEF);
         end
      end
   endtask

   task automatic test_range_error();
      int lat, cs_n, we_n, oe_n, cs_at;
      logic [31:0] rd;
      logic er;
      run_access(1'b1, 1'b0, 32'hFD, 32'h0, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL range_load: lat=%0d err=%b rdata=%h required 2 1 00000000", lat, er, rd);
      end
      checks++;
      if (cs_n !== 0) begin errors++; $display("FAIL range_load_cs: got %0d required 0", cs_n); end
      checks++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL range_other_hold: cpu_rdata=%h required deadbeef", cpu_rdata);
      end
      run_access(1'b1, 1'b1, 32'h100, 32'h12345678, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (er !== 1'b1 || cs_n !== 0 || we_n !== 0) begin
         errors++; $display("FAIL range_store: err=%b cs=%0d we=%0d required 1 0 0", er, cs_n, we_n);
      end
      checks++;
      if (mem_word(32'h0) !== 32'h03020100) begin
         errors++; $display("FAIL range_store_mem: got %h required 03020100", mem_word(32'h0));
      end
      run_access(1'b1, 1'b0, 32'hFC, 32'h0, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (er !== 1'b0 || rd !== 32'hFFFEFDFC || cs_n !== 1) begin
         errors++; $display("FAIL range_top_word: err=%b rdata=%h cs=%0d required 0 fffefdfc 1", er, rd, cs_n);
      end
   endtask

   task automatic test_alignment();
      int lat, cs_n, we_n, oe_n, cs_at;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h11, 32'hCAFEF00D, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL align_latency: got %0d required 2", lat); end
`ifdef DMEM_ALIGN_CHK_EN
      checks++;
      if (er !== 1'b1 || we_n !== 0) begin
         errors++; $display("FAIL align_store: err=%b we=%0d required 1 0", er, we_n);
      end
      checks++;
      if (mem_word(32'h10) !== 32'hDEADBEEF) begin
         errors++; $display("FAIL align_mem: got %h required deadbeef", mem_word(32'h10));
      end
`else
      checks++;
      if (er !== 1'b0 || we_n !== 1) begin
         errors++; $display("FAIL align_store: err=%b we=%0d required 0 1", er, we_n);
      end
      checks++;
      if (mem_word(32'h11) !== 32'hCAFEF00D || mem[8'h10] !== 8'hEF) begin
         errors++; $display("FAIL align_mem: word=%h byte10=%h required cafef00d ef", mem_word(32'h11), mem[8'h10]);
      end
`endif
   endtask

   task automatic test_reset_mid_access();
      int lat, cs_n, we_n, oe_n, cs_at;
      logic [31:0] rd;
      logic er;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h11223344;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (cs_ram !== 1'b1 || we !== 1'b1) begin
         errors++; $display("FAIL midrst_acc: cs=%b we=%b required 1 1", cs_ram, we);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (cs_ram !== 1'b0 || we !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 32'h0) begin
         errors++; $display("FAIL midrst_abort: cs=%b we=%b ack=%b rdata=%h required 0 0 0 0", cs_ram, we, cpu_ack, cpu_rdata);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL midrst_noack: got %b required 0", cpu_ack); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (mem_word(32'h40) !== 32'h43424140) begin
         errors++; $display("FAIL midrst_mem: got %h required 43424140", mem_word(32'h40));
      end
      run_access(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, er, cs_n, we_n, oe_n, cs_at);
      checks++;
      if (lat !== 2 || rd !== 32'h43424140 || er !== 1'b0) begin
         errors++; $display("FAIL midrst_reload: lat=%0d rdata=%h err=%b required 2 43424140 0", lat, rd, er);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_store_load();
      test_contention();
      test_range_error();
      test_alignment();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the byte-addressed, word-wide data memory. It shares the memory between the CPU MEM-stage load/store port and a debug/loader port. Each access runs through a fixed 3-state sequence that drives the memory's chip-select, write-enable, output-enable, address and write-data pins. It registers read data, returns a per-port acknowledge, and flags out-of-range accesses without touching the memory.

Parameters:
WIDTH_D, 32, data and address width in bits
DEPTH_D, 256, memory depth in bytes; valid word base addresses are 0..DEPTH_D-4

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_we  input  1  CPU access type: 1 = store, 0 = load
cpu_addr  input  WIDTH_D  CPU byte address
cpu_wdata  input  WIDTH_D  CPU store data
cpu_rdata  output  WIDTH_D  CPU load data, valid with cpu_ack
cpu_ack  output  1  one-cycle completion pulse for CPU
cpu_err  output  1  error flag, valid with cpu_ack
cpu_stall  output  1  combinational: cpu_req & ~cpu_ack
dbg_req  input  1  debug access request, held until dbg_ack
dbg_we  input  1  debug access type: 1 = write, 0 = read
dbg_addr  input  WIDTH_D  debug byte address
dbg_wdata  input  WIDTH_D  debug write data
dbg_rdata  output  WIDTH_D  debug read data, valid with dbg_ack
dbg_ack  output  1  one-cycle completion pulse for debug port
dbg_err  output  1  error flag, valid with dbg_ack
cs_ram  output  1  memory chip select
we  output  1  memory write enable
oe  output  1  memory output enable
d_addr  output  WIDTH_D  memory byte address
d_in  output  WIDTH_D  memory write data
d_out  input  WIDTH_D  memory read data (combinational from memory)

Behaviour:
- Reset: one clock domain; rst_n is asynchronous active-low. Async reset forces state=IDLE and rr_ptr=0 (CPU favoured). All of the following clear to 0: cs_ram, we, oe, d_addr, d_in, both rdata, both ack, both err.
- FSM states:
  - IDLE: when any request is present, arbitrate, latch the winner's we/addr/wdata and owner id, compute err, then go to ACC. With no request, stay in IDLE.
  - ACC: drive the memory for exactly one cycle, then go to RESP.
  - RESP: pulse the owner's ack and err, then go to IDLE.
- Arbitration (IDLE only):
  - A single request wins.
  - If both request, rr_ptr=0 grants CPU and rr_ptr=1 grants debug.
  - After each grant, rr_ptr points to the other port.
- Memory drive in ACC: cs_ram=~err_l, we=we_l & ~err_l, oe=~we_l & ~err_l, d_addr=addr_l, d_in=wdata_l. All are 0 in IDLE and RESP. The memory commits the write at the rising edge ending ACC.
- Read capture: at the edge ending ACC, a read with no error captures d_out into the owner's rdata. On error or write, the owner's rdata is set to 0. The other port's rdata holds its value.
- Latency: request seen in IDLE at cycle N → ack high in cycle N+2. Minimum 3 cycles per access. Back-to-back accesses alternate ports under contention.
- Handshake:
  - Requests are sampled only in IDLE.
  - A requester keeps req, we, addr and wdata stable until its ack.
  - A requester deasserts req in the cycle after ack. If req is still high in the next IDLE cycle, that is a new access.
  - Changes to request-side inputs during ACC or RESP are ignored.
- Error (range): err = addr > DEPTH_D-4, as an unsigned compare on the full width. With err set, no memory pins are asserted in ACC, ack still pulses, and err=1.
- Simultaneous events: a request arriving during ACC or RESP waits for IDLE. The loser of arbitration stays pending and is guaranteed the next grant.
- Reset mid-access: the access is aborted with no ack. A write already committed at an earlier edge stays in memory. A write in ACC that is cut by reset before the edge is not committed.

Optional Feature:
DMEM_ALIGN_CHK_EN
- Defined: err additionally sets when addr[1:0] != 2'b00. A misaligned store is suppressed and a misaligned load returns 0, both with err=1.
- Undefined: no alignment check. An unaligned base is passed to the memory unchanged, and the memory's byte assembly handles it.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → all outputs 0, cs_ram=0 for 5 idle cycles.
- CPU store then load: store cpu_addr=0x10, cpu_wdata=0xDEADBEEF → cpu_ack at N+2 with cs_ram=we=1 only in ACC. Then load 0x10 → cpu_rdata=0xDEADBEEF, cpu_err=0.
- Contention: cpu_req and dbg_req both high from reset (CPU load 0x10, debug load 0x20) → CPU acked first, debug acked 3 cycles later. Repeat with both held → grants alternate CPU, debug, CPU.
- Range error: dbg load addr=0xFD (DEPTH_D=256) → dbg_ack with dbg_err=1, dbg_rdata=0, cs_ram never high. Debug store addr=0x100 → memory unchanged.
- Alignment: with DMEM_ALIGN_CHK_EN, CPU store addr=0x11 → cpu_err=1, we never high. Without the macro, the same store completes with err=0 and bytes 0x11..0x14 written.
- Reset mid-access: assert rst_n low during ACC of a CPU store → no cpu_ack, FSM in IDLE. A subsequent load of the same address is serviced normally.
